// File: rtl/ifetch_queue_pkg.sv
// Shared RV32 fetch definitions: word size, instruction size and the
// {pc, inst} entry format held in the prefetch buffer.
package ifetch_queue_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetchEntry_t;

  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Parameterised synchronous FIFO used for both the fetched-instruction buffer
// and the request address-tag queue. Storage resets to zero so the head reads 0.
module ifetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  // Flush wins over both push and pop so a redirect leaves the buffer empty.
  assign doPush = push_i && !flush_i;
  assign doPop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: owns the fetch PC, issues credit-limited word requests,
// pairs in-order responses with their PC and buffers them for decode.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DepthLim = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetchPc_q, fetchPc_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   dataCount;
  logic [CW-1:0]   live;
  logic [CW:0]     creditSum;
  logic            tagFull, tagEmpty;
  logic            dataFull, dataEmpty;
  logic [XLEN-1:0] tagPc;
  fetchEntry_t     dataIn, dataHead;
  logic            reqValid, reqFire, rspAccept, rspKeep, instPop;

  // Only live (non-stale) requests need a buffer slot; stale ones are dropped on return.
  assign live      = outstanding - discard_q;
  assign creditSum = {1'b0, live} + {1'b0, dataCount};
  assign reqValid  = !reset && !redirect_valid && (creditSum < DepthLim) && !tagFull;
  assign reqFire   = reqValid && imem_req_ready;
  assign rspAccept = imem_rsp_valid && !tagEmpty;
  assign rspKeep   = rspAccept && (discard_q == '0) && !redirect_valid && !dataFull;
  assign instPop   = !dataEmpty && inst_ready && !redirect_valid;
  assign dataIn    = {tagPc, imem_rsp_data};

  always_comb begin
    fetchPc_d = fetchPc_q;
    discard_d = discard_q;
    if (redirect_valid) begin
      fetchPc_d = alignPc(redirect_pc);
      discard_d = outstanding - CW'(rspAccept);
    end else begin
      if (reqFire) fetchPc_d = fetchPc_q + XLEN'(INST_BYTES);
      if (rspAccept && (discard_q != '0)) discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchPc_q <= RESET_PC;
      discard_q <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      discard_q <= discard_d;
    end
  end

  // The tag queue occupancy doubles as the outstanding-request counter.
  ifetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) tagQueue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (reqFire),
    .pop_i   (rspAccept),
    .flush_i (1'b0),
    .wdata_i (fetchPc_q),
    .rdata_o (tagPc),
    .full_o  (tagFull),
    .empty_o (tagEmpty),
    .count_o (outstanding)
  );

  ifetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) dataQueue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rspKeep),
    .pop_i   (instPop),
    .flush_i (redirect_valid),
    .wdata_i (dataIn),
    .rdata_o (dataHead),
    .full_o  (dataFull),
    .empty_o (dataEmpty),
    .count_o (dataCount)
  );

  assign imem_req_valid = reqValid;
  assign imem_req_addr  = fetchPc_q;
  assign inst_valid     = !dataEmpty;
  assign inst_data      = dataHead.inst;
  assign inst_pc        = dataHead.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: a variable-latency memory plus a queue-based
// reference model of in-flight requests and buffered instructions.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          readyAt;
    bit          stale;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  flight_t     inflight[$];
  entry_t      fifoQ[$];
  logic [31:0] modelPc;
  logic [31:0] nextDecodePc;
  int          cycle;
  int          total;
  int          bad;

  int          pReqReady, pInstReady, pRedirect, pRsp, maxLat;
  bit          forceRedir;
  logic [31:0] forcePc;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] pickTarget();
    case ($urandom_range(3))
      0:       return $urandom & 32'h0000_0FFF;
      1:       return 32'hFFFF_FFF0 | ($urandom & 32'hF);
      2:       return 32'h0000_0100;
      default: return 32'h0000_0203;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic modelReset();
    inflight.delete();
    fifoQ.delete();
    modelPc      = RESET_PC;
    nextDecodePc = RESET_PC;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rstReqValid", imem_req_valid, 0);
    checkOutput("rstReqAddr", imem_req_addr, RESET_PC);
    checkOutput("rstInstValid", inst_valid, 0);
    checkOutput("rstInstData", inst_data, 0);
    checkOutput("rstInstPc", inst_pc, 0);
  endtask

  task automatic releaseReset();
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("postRstReqValid", imem_req_valid, 1);
    checkOutput("postRstReqAddr", imem_req_addr, RESET_PC);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic applyStimulus();
    bit      expReqValid, reqFire, rspFire;
    int      liveCnt;
    flight_t r;
    entry_t  e;

    @(posedge clk);
    #1;
    cycle++;
    imem_req_ready = ($urandom_range(99) < pReqReady);
    inst_ready     = ($urandom_range(99) < pInstReady);
    if (forceRedir) begin
      redirect_valid = 1'b1;
      redirect_pc    = forcePc;
      forceRedir     = 1'b0;
    end else begin
      redirect_valid = ($urandom_range(99) < pRedirect);
      redirect_pc    = pickTarget();
    end
    if (inflight.size() > 0 && inflight[0].readyAt <= cycle && $urandom_range(99) < pRsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(inflight[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;

    liveCnt = 0;
    foreach (inflight[i]) if (!inflight[i].stale) liveCnt++;
    expReqValid = !redirect_valid && (liveCnt + fifoQ.size() < DEPTH) && (inflight.size() < DEPTH);
    checkOutput("reqValid", imem_req_valid, expReqValid);
    checkOutput("reqAddr", imem_req_addr, modelPc);
    checkOutput("instValid", inst_valid, fifoQ.size() > 0);
    if (fifoQ.size() > 0) begin
      checkOutput("instPc", inst_pc, fifoQ[0].pc);
      checkOutput("instData", inst_data, fifoQ[0].data);
      if (inst_ready && !redirect_valid) checkOutput("order", inst_pc, nextDecodePc);
    end

    reqFire = expReqValid && imem_req_ready;
    rspFire = imem_rsp_valid;
    if (rspFire) r = inflight.pop_front();
    if (redirect_valid) begin
      fifoQ.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      modelPc      = redirect_pc & 32'hFFFF_FFFC;
      nextDecodePc = modelPc;
    end else begin
      if (inst_ready && fifoQ.size() > 0) begin
        e = fifoQ.pop_front();
        nextDecodePc = e.pc + 32'd4;
      end
      if (rspFire && !r.stale) begin
        checkOutput("noOverflow", fifoQ.size() < DEPTH, 1);
        fifoQ.push_back('{pc: r.addr, data: memWord(r.addr)});
      end
      if (reqFire) begin
        inflight.push_back('{addr: modelPc, readyAt: cycle + int'($urandom_range(maxLat, 1)), stale: 1'b0});
        modelPc = modelPc + 32'd4;
      end
    end
  endtask

  task automatic runPhase(input int n, input int reqRdy, input int instRdy, input int redir,
                          input int rsp, input int lat);
    pReqReady  = reqRdy;
    pInstReady = instRdy;
    pRedirect  = redir;
    pRsp       = rsp;
    maxLat     = lat;
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    cycle          = 0;
    forceRedir     = 1'b0;
    forcePc        = '0;
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    modelReset();
    #3;
    checkResetOutputs();
    releaseReset();

    // Zero-wait memory, decode always ready: sustained stream from address 0.
    runPhase(40, 100, 100, 0, 100, 1);
    // Decode stalled: credits run out after DEPTH requests, then drain.
    runPhase(15, 100, 0, 0, 100, 1);
    runPhase(10, 100, 100, 0, 100, 1);

    // Redirect coincident with a response, unaligned target.
    forceRedir = 1'b1;
    forcePc    = 32'h0000_0203;
    runPhase(10, 100, 100, 0, 100, 1);

    // Wrap across the top of the address space.
    forceRedir = 1'b1;
    forcePc    = 32'hFFFF_FFF8;
    runPhase(10, 100, 100, 0, 100, 1);

    // Latency 3 then redirect to 0x100 with requests in flight.
    runPhase(6, 100, 100, 0, 100, 3);
    forceRedir = 1'b1;
    forcePc    = 32'h0000_0100;
    runPhase(20, 100, 100, 0, 100, 3);

    runPhase(300, 70, 60, 8, 70, 4);

    // Asynchronous reset mid-stream.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkResetOutputs();
    modelReset();
    releaseReset();

    runPhase(300, 60, 70, 6, 80, 5);
    runPhase(100, 100, 100, 3, 100, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
